// File: rtl/run_ctrl.sv
// Run controller: resets the core, launches a program on start, counts RUN cycles until done/timeout.
// Latency: start edge -> core_reset low after RST_CYCLES+1 edges; result presented the edge after done/timeout.
// Backpressure: result held in REPORT (core parked in reset) until result_valid && result_ready.
//
// Ports:
//   clk, reset        single rising-edge clock; asynchronous active-high reset
//   start             launch request, sampled only in IDLE
//   core_done         done output of the processor top
//   core_reset        reset to the processor top (low only while RUN)
//   busy              controller not IDLE
//   result_valid/_ready  valid/ready handshake for cycle_count and timed_out
//   cycle_count       RUN cycles of the last run
//   timed_out         last run ended by TIMEOUT rather than core_done
module run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             core_done,
  output logic             core_reset,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] cycle_count,
  output logic             timed_out
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RST_INIT = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RESET_CORE = 2'd1,
    S_RUN        = 2'd2,
    S_REPORT     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             timed_out_q, timed_out_d;
  // The core reports done while its PC sits at index 0, which is also true
  // straight out of reset; done is only believed once it has been seen low.
  logic             armed_q, armed_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      timed_out_q   <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      timed_out_q   <= timed_out_d;
      armed_q       <= armed_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    timed_out_d   = timed_out_q;
    armed_d       = armed_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_RESET_CORE;
          rst_cnt_d     = RST_INIT;
          cycle_count_d = '0;
          timed_out_d   = 1'b0;
          armed_d       = 1'b0;
        end
      end
      S_RESET_CORE: begin
        if (rst_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RC_W'(1);
        end
      end
      S_RUN: begin
        // Counts every RUN edge, including the one that leaves RUN.
        cycle_count_d = cycle_count_q + CNT_W'(1);
        if (!core_done) begin
          armed_d = 1'b1;
        end
        // Done takes priority over a coincident timeout.
        if (armed_q && core_done) begin
          state_d     = S_REPORT;
          timed_out_d = 1'b0;
        end else if (cycle_count_q == TO_LAST) begin
          state_d     = S_REPORT;
          timed_out_d = 1'b1;
        end
      end
      S_REPORT: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state so core_reset follows reset asynchronously.
  assign core_reset   = (state_q != S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_REPORT);
  assign cycle_count  = cycle_count_q;
  assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed launches, expected results queued at launch and
// checked by an independent monitor when result_valid rises.
// Runs with RST_CYCLES=2, CNT_W=16, TIMEOUT=100.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        core_done;
  logic        core_reset;
  logic        busy;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] cycle_count;
  logic        timed_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] cnt;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_rv = 1'b0;

  run_ctrl #(.RST_CYCLES(2), .CNT_W(16), .TIMEOUT(100)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .core_done    (core_done),
    .core_reset   (core_reset),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .cycle_count  (cycle_count),
    .timed_out    (timed_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch a run; core_reset must stay high for exactly 2 edges after the launch edge.
  task automatic launch(input bit do_push, input logic [15:0] cnt, input logic to);
    exp_t e;
    if (do_push) begin
      e.cnt = cnt;
      e.to  = to;
      exp_q.push_back(e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("launch_busy", busy, 1);
    check("launch_core_reset_e0", core_reset, 1);
    tick();
    check("launch_core_reset_e1", core_reset, 1);
    tick();
    check("launch_core_reset_e2", core_reset, 0);
  endtask

  // Drive core_done for n RUN edges: high on done_cyc, and on cycle 1 if early.
  task automatic run_cycles(input int n, input bit early, input int done_cyc);
    for (int i = 1; i <= n; i++) begin
      core_done = (i == done_cyc) || (early && i == 1);
      tick();
    end
    core_done = 1'b0;
  endtask

  task automatic accept;
    check("report_valid", result_valid, 1);
    check("report_core_reset", core_reset, 1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("after_accept_valid", result_valid, 0);
    check("after_accept_busy", busy, 0);
  endtask

  // Monitor: one expected result consumed per presentation of result_valid.
  always @(negedge clk) begin
    if (result_valid && !prev_rv) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got count %0d, expected no result", cycle_count);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_count", cycle_count, mon_e.cnt);
        check("result_timed_out", timed_out, mon_e.to);
      end
    end
    prev_rv = result_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    core_done    = 1'b0;
    result_ready = 1'b0;
    #2;
    // 1: reset values
    check("rst_core_reset", core_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_count", cycle_count, 0);
    check("rst_timed_out", timed_out, 0);
    tick();
    reset = 1'b0;
    tick();

    // 2: early done ignored, done on cycle 11
    launch(1'b1, 16'd11, 1'b0);
    run_cycles(11, 1'b1, 11);
    accept();

    // 3: timeout after 100 RUN cycles
    launch(1'b1, 16'd100, 1'b1);
    run_cycles(100, 1'b0, 0);
    accept();

    // 4: done on cycle 100 beats timeout
    launch(1'b1, 16'd100, 1'b0);
    run_cycles(100, 1'b0, 100);
    accept();

    // 5: result held under backpressure, start ignored
    launch(1'b1, 16'd3, 1'b0);
    run_cycles(3, 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      tick();
      check("hold_valid", result_valid, 1);
      check("hold_count", cycle_count, 3);
      check("hold_core_reset", core_reset, 1);
    end
    start        = 1'b1;
    result_ready = 1'b1;
    tick();
    start        = 1'b0;
    result_ready = 1'b0;
    check("hs_valid_drop", result_valid, 0);
    check("hs_no_relaunch", busy, 0);
    tick();
    check("idle_stays", busy, 0);

    // 6: asynchronous reset mid-RUN
    launch(1'b0, 16'd0, 1'b0);
    run_cycles(40, 1'b0, 0);
    check("mid_run_count", cycle_count, 40);
    check("mid_run_core_reset", core_reset, 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_core_reset", core_reset, 1);
    check("arst_busy", busy, 0);
    check("arst_count", cycle_count, 0);
    check("arst_valid", result_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    launch(1'b1, 16'd11, 1'b0);
    run_cycles(11, 1'b1, 11);
    accept();

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
